car_sprite_src: RTL
===================

# car_sprite_src

Downstream render stage for the car sprite RAMs: converts the current scan pixel (x, y) into a sprite-RAM read address, absorbs the RAM's one-cycle read latency, and produces a registered 12-bit sprite pixel plus a valid flag for the video blender. Position, horizontal mirroring and hide are double-buffered and committed only at frame start, so the sprite never tears mid-frame. It optionally alternates between two animation frames held in two sprite RAMs.

## Interface

- CD, default 12: colour depth; matches sprite RAM data width.
- SIDE_BITS, default 5: log2 of the square sprite side (32×32); RAM address width is 2*SIDE_BITS (10).
- KEY_COLOR, default 12'h000: chroma-key value treated as transparent.
- ANIM_DIV, default 8: frame_start pulses per animation frame toggle (≥1).
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- x  in  11  current scan column
- y  in  11  current scan row
- frame_start  in  1  one-cycle pulse, issued during vertical blanking
- wr_en  in  1  register write strobe
- reg_addr  in  2  0 = x0, 1 = y0, 2 = ctrl
- wr_data  in  11  write data (ctrl: bit0 flip, bit1 anim_en, bit2 hide)
- addr_r  out  2*SIDE_BITS  read address to sprite RAMs
- dout_f0  in  CD  frame-0 RAM read data
- dout_f1  in  CD  frame-1 RAM read data
- sprite_rgb  out  CD  registered sprite pixel
- sprite_valid  out  1  sprite pixel is opaque and inside the sprite region

## Operation

- Shadow registers x0_s, y0_s, ctrl_s are loaded on wr_en. Unused reg_addr 3 is ignored.
- Active registers x0_a, y0_a, ctrl_a are copied from the shadows on frame_start.
- If wr_en and frame_start occur in the same cycle, the active copy takes the pre-write shadow value. The new value applies at the next frame_start.
- Offsets are computed as xr = (x − x0_a) mod 2048 and yr = (y − y0_a) mod 2048, both 11-bit with wrap-around.
- in_region = (xr < 2^SIDE_BITS) && (yr < 2^SIDE_BITS) && !hide.
- Column index: xc = flip ? ~xr[SIDE_BITS-1:0] : xr[SIDE_BITS-1:0].
- addr_r = {yr[SIDE_BITS-1:0], xc}. It is combinational from x, y and the active registers, and is driven even outside the region.
- Pipeline stage 1 registers in_region and frame_sel.
- Stage 2 selects pix = frame_sel ? dout_f1 : dout_f0.
  - sprite_rgb is registered from pix.
  - sprite_valid is registered from stage-1 in_region && (pix != KEY_COLOR).
- Animation FSM has states IDLE and RUN, with counter anim_cnt (0..ANIM_DIV−1) and frame_sel.
  - IDLE → RUN when, at frame_start, the committed anim_en is 1.
  - In RUN, each frame_start increments anim_cnt. At ANIM_DIV−1, anim_cnt wraps to 0 and frame_sel toggles.
  - RUN → IDLE when, at frame_start, the committed anim_en is 0. On that transition anim_cnt and frame_sel are cleared.

## Timing

- Latency: x/y at cycle n → addr_r at cycle n → RAM dout at n+1 → sprite_rgb/sprite_valid at n+2. The blender delays its background path by 2 cycles.
- Throughput is one pixel per clock with no stalls.
- Reset (asynchronous, reset_n low) sets:
  - all shadow and active registers to 0;
  - anim_cnt = 0, frame_sel = 0, FSM = IDLE;
  - both pipeline stages, sprite_rgb and sprite_valid to 0.
- Reset asserted mid-line forces outputs to 0 immediately. The first valid output after release is 2 cycles after reset_n rises.
- Active registers change only on the cycle after frame_start. frame_sel changes on the same edge, so one frame is always uniform.

## Configuration

- CAR_SPRITE_ANIM_EN defined: the animation FSM, anim_cnt and frame_sel are built, and dout_f1 is used.
- CAR_SPRITE_ANIM_EN undefined:
  - frame_sel is tied to 0 and the FSM and counter are removed;
  - ctrl bit1 is stored but has no effect;
  - dout_f1 is unused.

## Test plan

- Reset, write x0=100, y0=50, pulse frame_start, scan (100,50) → addr_r=0 the same cycle; sprite_rgb = RAM[0] and sprite_valid=1 two cycles later (RAM[0]=12'hF00).
- Same setup, scan (131,81) → addr_r=1023. Scan (132,81) and (99,50) → sprite_valid=0 at n+2.
- Set flip=1 and commit, scan (100,50) → addr_r=31. Write x0=300 without frame_start → position unchanged until the next pulse.
- RAM word = 12'h000 (key) inside the region → sprite_valid=0 and sprite_rgb=12'h000. Set hide=1 → sprite_valid=0 everywhere.
- With CAR_SPRITE_ANIM_EN, ANIM_DIV=2, anim_en=1 committed → frame_sel toggles every 2nd frame_start. Output alternates between dout_f0 and dout_f1. Clearing anim_en returns to dout_f0 after the commit.
- Set x0=2040, y0=0, scan x=0 → xr=8 and addr_r=8 (wrap-around). Write ctrl in the same cycle as frame_start → takes effect one frame later.

Source files
------------

// File: rtl/car_sprite_src.sv
`default_nettype none
// ============================================================================
// Module   : car_sprite_src
// Brief    : Car sprite render stage. Maps the scan pixel to a sprite-RAM
//            address, absorbs the RAM latency, and emits pixel + valid.
//            Optional two-frame animation when CAR_SPRITE_ANIM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module car_sprite_src #(
  parameter int            CD        = 12,
  parameter int            SIDE_BITS = 5,
  parameter logic [CD-1:0] KEY_COLOR = {CD{1'b0}},
  parameter int            ANIM_DIV  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [10:0]            x,
  input  logic [10:0]            y,
  input  logic                   frame_start,
  input  logic                   wr_en,
  input  logic [1:0]             reg_addr,
  input  logic [10:0]            wr_data,
  output logic [2*SIDE_BITS-1:0] addr_r,
  input  logic [CD-1:0]          dout_f0,
  input  logic [CD-1:0]          dout_f1,
  output logic [CD-1:0]          sprite_rgb,
  output logic                   sprite_valid
);

  localparam int c_CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [10:0] r_x0_s, r_y0_s, r_x0_a, r_y0_a;
  logic [2:0]  r_ctrl_s, r_ctrl_a;

  // Shadow writes and frame-start commit; the commit sees the pre-write shadow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x0_s   <= '0;
      r_y0_s   <= '0;
      r_ctrl_s <= '0;
      r_x0_a   <= '0;
      r_y0_a   <= '0;
      r_ctrl_a <= '0;
    end else begin
      if (frame_start) begin
        r_x0_a   <= r_x0_s;
        r_y0_a   <= r_y0_s;
        r_ctrl_a <= r_ctrl_s;
      end
      if (wr_en) begin
        case (reg_addr)
          2'd0:    r_x0_s   <= wr_data;
          2'd1:    r_y0_s   <= wr_data;
          2'd2:    r_ctrl_s <= wr_data[2:0];
          default: ;
        endcase
      end
    end
  end

  logic [10:0]          w_xr, w_yr;
  logic [SIDE_BITS-1:0] w_xc;
  logic                 w_in_region;
  logic                 w_frame_sel;

  assign w_xr        = x - r_x0_a;
  assign w_yr        = y - r_y0_a;
  assign w_in_region = (w_xr[10:SIDE_BITS] == '0) && (w_yr[10:SIDE_BITS] == '0) && !r_ctrl_a[2];
  assign w_xc        = r_ctrl_a[0] ? ~w_xr[SIDE_BITS-1:0] : w_xr[SIDE_BITS-1:0];
  assign addr_r      = {w_yr[SIDE_BITS-1:0], w_xc};

  logic          r_in_region_d;
  logic [CD-1:0] w_pix;

`ifdef CAR_SPRITE_ANIM_EN
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } anim_state_t;

  anim_state_t          r_state;
  logic [c_CNT_W-1:0]   r_anim_cnt;
  logic                 r_frame_sel;
  logic                 r_frame_sel_d;

  // Decision uses the anim_en being committed on this frame_start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_anim_cnt  <= '0;
      r_frame_sel <= 1'b0;
    end else if (frame_start) begin
      case (r_state)
        ST_IDLE: begin
          if (r_ctrl_s[1]) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (!r_ctrl_s[1]) begin
            r_state     <= ST_IDLE;
            r_anim_cnt  <= '0;
            r_frame_sel <= 1'b0;
          end else if (r_anim_cnt == c_CNT_W'(ANIM_DIV - 1)) begin
            r_anim_cnt  <= '0;
            r_frame_sel <= ~r_frame_sel;
          end else begin
            r_anim_cnt  <= r_anim_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_frame_sel = r_frame_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_frame_sel_d <= 1'b0;
    else          r_frame_sel_d <= w_frame_sel;
  end

  assign w_pix = r_frame_sel_d ? dout_f1 : dout_f0;

  logic w_unused;
  assign w_unused = &{1'b0, r_ctrl_a[1]};
`else
  assign w_frame_sel = 1'b0;
  assign w_pix       = dout_f0;

  logic w_unused;
  assign w_unused = &{1'b0, r_ctrl_a[1], dout_f1, w_frame_sel, c_CNT_W[0]};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_region_d <= 1'b0;
      sprite_rgb    <= '0;
      sprite_valid  <= 1'b0;
    end else begin
      r_in_region_d <= w_in_region;
      sprite_rgb    <= w_pix;
      sprite_valid  <= r_in_region_d && (w_pix != KEY_COLOR);
    end
  end

endmodule
`default_nettype wire
